// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage : serial_subtractor_pkg

// File: rtl/fs_bit_cell.sv
// One-bit full subtractor: x - y - z producing difference d and borrow b.
module fs_bit_cell (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic d,
   output logic b
);

   assign d = x ^ y ^ z;
   assign b = (~x & z) | (~x & y) | (y & z);

endmodule : fs_bit_cell

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a-b LSB-first over WIDTH RUN cycles,
// then publishes diff/borrow_out with a one-cycle done pulse.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int unsigned   CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e            state_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [WIDTH-2:0]  part_q;
   logic              borrow_q;
   logic [CW-1:0]     cnt_q;
   logic              busy_q;
   logic              done_q;
   logic [WIDTH-1:0]  diff_q;
   logic              bout_q;

   logic              bit_d;
   logic              borrow_d;
   logic [WIDTH-1:0]  part_d;

   fs_bit_cell u_cell (
      .x (a_q[0]),
      .y (b_q[0]),
      .z (borrow_q),
      .d (bit_d),
      .b (borrow_d)
   );

   // New bit enters at the MSB; the oldest partial bit falls off the bottom.
   assign part_d = {bit_d, part_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         part_q   <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  a_q      <= a;
                  b_q      <= b;
                  part_q   <= '0;
                  borrow_q <= 1'b0;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= ST_RUN;
               end
            end
            ST_RUN: begin
               a_q      <= a_q >> 1;
               b_q      <= b_q >> 1;
               part_q   <= part_d[WIDTH-1:1];
               borrow_q <= borrow_d;
               cnt_q    <= cnt_q + CW'(1);
               // Last bit: part_d already holds the complete difference.
               if (cnt_q == LAST) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  diff_q  <= part_d;
                  bout_q  <= borrow_d;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign diff       = diff_q;
   assign borrow_out = bout_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=3 instances).
module tb_serial_subtractor;

   localparam int unsigned W  = 8;
   localparam int unsigned W3 = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          start8, busy8, done8, bo8;
   logic [W-1:0]  a8, b8, diff8;
   logic          start3, busy3, done3, bo3;
   logic [W3-1:0] a3, b3, diff3;

   int          n_chk  = 0;
   int          n_fail = 0;
   int unsigned cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_subtractor #(.WIDTH(W)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
   );

   serial_subtractor #(.WIDTH(W3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
      .busy(busy3), .done(done3), .diff(diff3), .borrow_out(bo3)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] d;
      logic       bo;
   } vec_t;

   // Reference: plain modular arithmetic on integers.
   function automatic int ref_diff(input int x, input int y, input int w);
      int m;
      m = 1 << w;
      return ((x - y) % m + m) % m;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one WIDTH=8 operation; returns at the cycle done is high.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, output int unsigned dcyc);
      logic [7:0] hold_d;
      logic       hold_b;
      logic       bad;
      int         lat;
      hold_d = diff8;
      hold_b = bo8;
      a8 = a; b8 = b; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      lat = 0;
      bad = 1'b0;
      while (!done8 && lat < 40) begin
         if (!busy8 || diff8 !== hold_d || bo8 !== hold_b) bad = 1'b1;
         tick();
         lat++;
      end
      dcyc = cyc;
      chk("latency8", 32'(lat), 32'(W));
      chk("run_busy_and_hold8", 32'(bad), 32'd0);
   endtask

   task automatic op3(input logic [2:0] a, input logic [2:0] b);
      int lat;
      a3 = a; b3 = b; start3 = 1'b1;
      tick();
      start3 = 1'b0;
      lat = 0;
      while (!done3 && lat < 40) begin
         tick();
         lat++;
      end
      chk("latency3", 32'(lat), 32'(W3));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl [6];
      int unsigned dc, prev_dc;
      int          lat, ndone;
      logic        bad;
      int          ra, rb;

      tbl[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
      tbl[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
      tbl[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
      tbl[3] = '{8'h80, 8'h7F, 8'h01, 1'b0};
      tbl[4] = '{8'h7F, 8'h80, 8'hFF, 1'b1};
      tbl[5] = '{8'h00, 8'h00, 8'h00, 1'b0};

      rst = 1'b1; start8 = 1'b0; start3 = 1'b0;
      a8 = '0; b8 = '0; a3 = '0; b3 = '0;
      repeat (3) tick();
      chk("rst_busy8", 32'(busy8), 32'd0);
      chk("rst_done8", 32'(done8), 32'd0);
      chk("rst_diff8", 32'(diff8), 32'd0);
      chk("rst_borrow8", 32'(bo8), 32'd0);
      chk("rst_busy3", 32'(busy3), 32'd0);
      chk("rst_diff3", 32'(diff3), 32'd0);
      rst = 1'b0;
      tick();

      // Directed table, back-to-back: each start issued in the IDLE cycle after DONE.
      prev_dc = 0;
      for (int i = 0; i < 6; i++) begin
         op8(tbl[i].a, tbl[i].b, dc);
         chk("tbl_done", 32'(done8), 32'd1);
         chk("tbl_diff", 32'(diff8), 32'(tbl[i].d));
         chk("tbl_borrow", 32'(bo8), 32'(tbl[i].bo));
         if (i > 0) chk("b2b_spacing", 32'(dc - prev_dc), 32'(W + 2));
         prev_dc = dc;
         tick();
         chk("done_one_cycle", 32'(done8), 32'd0);
         chk("idle_not_busy", 32'(busy8), 32'd0);
      end

      // start held high with new operands during RUN must be ignored.
      a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
      tick();
      a8 = 8'hAA;
      lat = 0;
      bad = 1'b0;
      while (!done8 && lat < 40) begin
         if (!busy8) bad = 1'b1;
         tick();
         lat++;
      end
      chk("hold_latency", 32'(lat), 32'(W));
      chk("hold_busy", 32'(bad), 32'd0);
      chk("hold_diff", 32'(diff8), 32'h0F);
      chk("hold_borrow", 32'(bo8), 32'd0);
      tick();
      start8 = 1'b0;
      ndone = 0;
      repeat (2 * W) begin
         tick();
         if (done8) ndone++;
      end
      chk("hold_single_done", 32'(ndone), 32'd0);

      // Reset in the 4th RUN cycle aborts without a done pulse.
      a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      repeat (3) tick();
      chk("abort_busy_before", 32'(busy8), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_done", 32'(done8), 32'd0);
      chk("abort_busy", 32'(busy8), 32'd0);
      chk("abort_diff", 32'(diff8), 32'd0);
      chk("abort_borrow", 32'(bo8), 32'd0);
      ndone = 0;
      repeat (2 * W) begin
         tick();
         if (done8 || busy8) ndone++;
      end
      chk("abort_quiet", 32'(ndone), 32'd0);
      op8(8'h5A, 8'h3C, dc);
      chk("after_abort_diff", 32'(diff8), 32'h1E);
      chk("after_abort_borrow", 32'(bo8), 32'd0);
      tick();

      // Random operands against the arithmetic model.
      repeat (40) begin
         ra = int'($urandom_range(0, 255));
         rb = int'($urandom_range(0, 255));
         op8(8'(ra), 8'(rb), dc);
         chk("rand_diff", 32'(diff8), 32'(ref_diff(ra, rb, W)));
         chk("rand_borrow", 32'(bo8), 32'(ra < rb));
         tick();
      end

      // Exhaustive sweep on the 3-bit instance.
      for (int x = 0; x < 8; x++) begin
         for (int y = 0; y < 8; y++) begin
            op3(3'(x), 3'(y));
            chk("sweep3_diff", 32'(diff3), 32'(ref_diff(x, y, W3)));
            chk("sweep3_borrow", 32'(bo3), 32'(x < y));
            tick();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_serial_subtractor
